// File: rtl/data_memory_line.sv
// Line-wide (256-bit) backing memory behind the data cache.
// Serves one whole-line read or write per request. The acknowledge comes a
// fixed LATENCY cycles after acceptance, then one recovery cycle follows
// before the next request can be taken.
module data_memory_line #(
  parameter int LINES   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int DATA_W = 256;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, RECOVER} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  accept;
  logic                  commit;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      commit_idx;
  logic [DATA_W-1:0]     commit_data;
  logic                  commit_wr;

  // Request copy taken at acceptance; later input changes are ignored
  logic [IDX_W-1:0]      idx_p0;
  logic [DATA_W-1:0]     data_p0;
  logic                  wr_p0;

  logic [DATA_W-1:0]     mem [LINES];

  // Offset bits and bits above the index are don't-care (high bits alias)
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  assign addr_idx = addr_i[5 +: IDX_W];
  assign ack_o    = (state == ACK);

  // State and latency counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; commit marks the edge that enters ACK
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    commit      = 1'b0;
    commit_idx  = idx_p0;
    commit_data = data_p0;
    commit_wr   = wr_p0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          cnt_nxt = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle build commits straight from the live inputs
            state_nxt   = ACK;
            commit      = 1'b1;
            commit_idx  = addr_idx;
            commit_data = data_i;
            commit_wr   = write_i;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (!enable_i) begin
          // Requester withdrew: drop the request without touching memory
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_nxt = ACK;
            commit    = 1'b1;
          end
        end
      end
      ACK:     state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request at acceptance
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_p0  <= addr_idx;
      data_p0 <= data_i;
      wr_p0   <= write_i;
    end
  end

  // Line array write; contents survive reset, a reset on the commit edge blocks it
  always_ff @(posedge clk_i) begin
    if (commit && commit_wr && !rst_i) begin
      mem[commit_idx] <= commit_data;
    end
  end

  // Read data register, updated only by a completing read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (commit && !commit_wr) begin
      data_o <= mem[commit_idx];
    end
  end

endmodule

// File: tb/tb_data_memory_line.sv
// Scoreboard bench for data_memory_line: a LATENCY=10 instance and a
// LATENCY=1 instance. Stimulus pushes the expected ack cycle and read data;
// monitors pop and compare whenever ack is seen.
module tb_data_memory_line;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr, addr1;
  logic [255:0] din, din1;
  logic         en, en1, wr, wr1;
  logic         ack, ack1;
  logic [255:0] dout, dout1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    logic         wr;
    logic [255:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  localparam logic [255:0] P3 = {8{32'hA5A5_0003}};
  localparam logic [255:0] W4 = {8{32'h1234_5678}};
  localparam logic [255:0] D8 = {8{32'hDEAD_0100}};
  localparam logic [255:0] BX = {8{32'hBAD0_BAD0}};
  localparam logic [255:0] BY = {8{32'h5555_AAAA}};
  localparam logic [255:0] P1 = {8{32'h0F0F_0001}};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_memory_line #(.LINES(512), .LATENCY(10)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(din),
    .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout)
  );

  data_memory_line #(.LINES(512), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(din1),
    .enable_i(en1), .write_i(wr1), .ack_o(ack1), .data_o(dout1)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the LATENCY=10 instance
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL ack0_unexpected: ack at cycle %0d with nothing outstanding", cyc);
      end else begin
        e0 = q0.pop_front();
        if (cyc != e0.cyc) begin
          errors++;
          $display("FAIL ack0_cycle: got cycle %0d expected %0d", cyc, e0.cyc);
        end
        if (!e0.wr) begin
          checks++;
          if (dout !== e0.data) begin
            errors++;
            $display("FAIL ack0_data: got %h expected %h", dout, e0.data);
          end
        end
      end
    end
  end

  // Monitor for the LATENCY=1 instance
  always @(negedge clk) begin
    if (ack1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL ack1_unexpected: ack at cycle %0d with nothing outstanding", cyc);
      end else begin
        e1 = q1.pop_front();
        if (cyc != e1.cyc) begin
          errors++;
          $display("FAIL ack1_cycle: got cycle %0d expected %0d", cyc, e1.cyc);
        end
        if (!e1.wr) begin
          checks++;
          if (dout1 !== e1.data) begin
            errors++;
            $display("FAIL ack1_data: got %h expected %h", dout1, e1.data);
          end
        end
      end
    end
  end

  task automatic issue0(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] e, output int t0);
    @(posedge clk); #1;
    en = 1'b1; wr = w; addr = a; din = d;
    t0 = cyc;
    q0.push_back('{t0 + 10, w, e});
  endtask

  task automatic wait_ack0(input string name, output int tack);
    tack = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        tack = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", name);
  endtask

  // Full request as the cache issues it: enable held one cycle past ack
  task automatic req0(input logic w, input logic [31:0] a, input logic [255:0] d,
                      input logic [255:0] e, input string name);
    int t0, ta;
    issue0(w, a, d, e, t0);
    wait_ack0(name, ta);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_ack_low_after"}, 256'(ack), 256'(0));
    if (!w) chk({name, "_hold1"}, dout, e);
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0;
    @(negedge clk);
    if (!w) chk({name, "_hold2"}, dout, e);
  endtask

  // Request withdrawn in cycle 4; the monitors flag any ack
  task automatic abort0(input logic w, input logic [31:0] a, input logic [255:0] d);
    @(posedge clk); #1;
    en = 1'b1; wr = w; addr = a; din = d;
    repeat (4) @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int tw, tr, ta, t0;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", 256'(ack), 256'(0));
    chk("reset_dout", dout, '0);
    chk("reset_ack1", 256'(ack1), 256'(0));
    chk("reset_dout1", dout1, '0);

    // Preload line 3, read it back
    req0(1'b1, 32'h0000_0060, P3, '0, "t1_preload");
    req0(1'b0, 32'h0000_0060, '0, P3, "t1_read");

    // Write line 4, read with different offset bits, line 3 intact
    req0(1'b1, 32'h0000_0080, W4, '0, "t2_write");
    req0(1'b0, 32'h0000_009C, '0, W4, "t2_read_offset");
    req0(1'b0, 32'h0000_0060, '0, P3, "t2_line3");

    // Write-back then refill with enable held throughout
    issue0(1'b1, 32'h0000_0100, D8, '0, tw);
    wait_ack0("t3_wb", ta);
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("t3_ack_low_recover", 256'(ack), 256'(0));
    @(posedge clk); #1;
    tr = cyc;
    q0.push_back('{tr + 10, 1'b0, D8});
    wait_ack0("t3_refill", ta);
    chk("t3_refill_turnaround", 256'(ta - tw), 256'(22));
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    chk("t3_refill_dout", dout, D8);

    // Aborted read leaves data_o alone; aborted write leaves the line alone
    abort0(1'b0, 32'h0000_0080, '0);
    chk("t4_dout_unchanged", dout, D8);
    abort0(1'b1, 32'h0000_0080, BX);
    req0(1'b0, 32'h0000_0080, '0, W4, "t4_line_intact");

    // Reset in cycle 5 of a write, then reset together with enable in IDLE
    @(posedge clk); #1;
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; din = BY;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_ack_in_reset", 256'(ack), 256'(0));
    chk("t5_dout_reset", dout, '0);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; wr = 1'b0;
    repeat (15) @(negedge clk);
    req0(1'b0, 32'h0000_0060, '0, P3, "t5_after_reset");

    // LATENCY=1 instance: write line 3, then back-to-back reads via alias
    @(posedge clk); #1;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0060; din1 = P1;
    t0 = cyc;
    q1.push_back('{t0 + 1, 1'b1, '0});
    @(posedge clk); #1;
    en1 = 1'b0; wr1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_4060; din1 = BX;
    t0 = cyc;
    q1.push_back('{t0 + 1, 1'b0, P1});
    q1.push_back('{t0 + 4, 1'b0, P1});
    repeat (4) @(posedge clk);
    #1;
    en1 = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_dout1_held", dout1, P1);

    chk("q0_drained", 256'(q0.size()), 256'(0));
    chk("q1_drained", 256'(q1.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

endmodule
